// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the integer-to-float pipeline.
//   rm_e        rounding-mode encoding as seen on the rm port
//   F32_BIAS    binary32 exponent bias
//   F32_MANT_W  binary32 stored-mantissa width
//   s1_t, s2_t  stage payloads. Magnitudes are held left-aligned in
//               MAX_IN_W bits, so one datapath serves every legal IN_W.
package fpu_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    localparam int F32_BIAS   = 127;
    localparam int F32_MANT_W = 23;
    localparam int MAX_IN_W   = 64;
    localparam int LZ_W       = $clog2(MAX_IN_W);

    typedef struct packed {
        logic                sign;
        logic [MAX_IN_W-1:0] mag;
    } s1_t;

    typedef struct packed {
        logic                sign;
        logic                zero;
        logic [LZ_W-1:0]     lz;
        logic [MAX_IN_W-1:0] norm;
    } s2_t;

endpackage

// File: rtl/itof_pipe_lzc.sv
// lzc: combinational leading-zero count.
//   a    W-bit operand
//   cnt  number of leading zeros; value for a == 0 is don't-care
module lzc #(
    parameter int W = 64
) (
    input  logic [W-1:0]         a,
    output logic [$clog2(W)-1:0] cnt
);

    localparam int CW = $clog2(W);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: three-stage integer to IEEE-754 binary32 converter.
//   clk, rstn              clock, asynchronous active-low reset
//   x, is_unsigned, rm     operand, signedness, rounding mode
//   in_valid / in_ready    input handshake
//   y, inexact             binary32 result and inexact flag
//   out_valid / out_ready  output handshake
// Build option ITOF_ROUND_MODES_EN: when defined, rm selects the rounding
// mode; when undefined, rm is ignored and conversion always rounds to
// nearest even.
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [IN_W-1:0] x,
    input  logic            is_unsigned,
    input  logic [1:0]      rm,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     y,
    output logic            inexact,
    output logic            out_valid,
    input  logic            out_ready
);

    logic v1, v2, v3;
    logic en1, en2, en3;
    s1_t  s1, s1_d;
    s2_t  s2, s2_d;
    rm_e  rm_eff;

    // A stage accepts when it is empty or its contents move on this cycle.
    assign en3       = ~v3 | out_ready;
    assign en2       = ~v2 | en3;
    assign en1       = ~v1 | en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    // S1: sign and magnitude. INT_MIN negates to itself, which read as
    // unsigned is exactly 2^(IN_W-1).
    logic            sign_in;
    logic [IN_W-1:0] mag_in;

    assign sign_in = ~is_unsigned & x[IN_W-1];
    assign mag_in  = sign_in ? -x : x;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = sign_in;
        s1_d.mag  = MAX_IN_W'(mag_in) << (MAX_IN_W - IN_W);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) s1 <= s1_d;
        end
    end

    // S2: normalise.
    logic [LZ_W-1:0] lz1;

    lzc #(.W(MAX_IN_W)) u_lzc (
        .a   (s1.mag),
        .cnt (lz1)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1.sign;
        s2_d.zero = (s1.mag == '0);
        s2_d.lz   = lz1;
        s2_d.norm = s1.mag << lz1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) s2 <= s2_d;
        end
    end

`ifdef ITOF_ROUND_MODES_EN
    rm_e rm1, rm2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rm1 <= RM_RNE;
            rm2 <= RM_RNE;
        end else begin
            if (en1 && in_valid) rm1 <= rm_e'(rm);
            if (en2 && v1)       rm2 <= rm1;
        end
    end

    assign rm_eff = rm2;
`else
    logic unused_rm;

    assign unused_rm = ^rm;
    assign rm_eff    = RM_RNE;
`endif

    // S3: round and pack. Leading one sits at bit MAX_IN_W-1 of norm.
    logic [F32_MANT_W-1:0] frac;
    logic                  g, st, inc, carry;
    logic [F32_MANT_W+1:0] sum;
    logic [7:0]            exp_d;
    logic [31:0]           y_d;
    logic                  inexact_d;

    assign frac = s2.norm[MAX_IN_W-2 -: F32_MANT_W];
    assign g    = s2.norm[MAX_IN_W-2-F32_MANT_W];
    assign st   = |s2.norm[MAX_IN_W-3-F32_MANT_W:0];

    always_comb begin
        inc = 1'b0;
        case (rm_eff)
            RM_RNE: inc = g & (st | frac[0]);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = s2.sign & (g | st);
            RM_RUP: inc = ~s2.sign & (g | st);
            default: inc = 1'b0;
        endcase
    end

    assign sum   = {1'b0, 1'b1, frac} + (F32_MANT_W+2)'(inc);
    assign carry = sum[F32_MANT_W+1];
    assign exp_d = 8'(F32_BIAS + IN_W - 1) - 8'(s2.lz) + 8'(carry);

    always_comb begin
        if (s2.zero) begin
            y_d       = '0;
            inexact_d = 1'b0;
        end else begin
            y_d       = {s2.sign, exp_d,
                         carry ? {F32_MANT_W{1'b0}} : sum[F32_MANT_W-1:0]};
            inexact_d = g | st;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3      <= 1'b0;
            y       <= '0;
            inexact <= 1'b0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                y       <= y_d;
                inexact <= inexact_d;
            end
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x;
    logic        is_unsigned;
    logic [1:0]  rm;
    logic        in_valid, in_ready;
    logic [31:0] y;
    logic        inexact, out_valid, out_ready;

    logic [63:0] x64;
    logic        uns64;
    logic [1:0]  rm64;
    logic        iv64, ir64;
    logic [31:0] y64;
    logic        inx64, ov64, or64;

    int errors = 0;
    int checks = 0;

    logic [32:0] q32[$];
    logic [32:0] q64[$];

    int          occ = 0;
    logic        pend_in = 1'b0, pend_out = 1'b0;
    logic        hold_pend = 1'b0;
    logic [32:0] hold_val = '0;
    logic        rand_ready = 1'b0;

`ifdef ITOF_ROUND_MODES_EN
    localparam logic [31:0] E_MAX_RTZ  = 32'h4EFFFFFF;
    localparam logic [31:0] E_TIE_RUP  = 32'h4B800001;
    localparam logic [31:0] E_NEG_RDN  = 32'hCB800001;
`else
    localparam logic [31:0] E_MAX_RTZ  = 32'h4F000000;
    localparam logic [31:0] E_TIE_RUP  = 32'h4B800000;
    localparam logic [31:0] E_NEG_RDN  = 32'hCB800000;
`endif

    always #5 clk = ~clk;

    itof_pipe #(.IN_W(32)) dut32 (
        .clk         (clk),
        .rstn        (rstn),
        .x           (x),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .y           (y),
        .inexact     (inexact),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    itof_pipe #(.IN_W(64)) dut64 (
        .clk         (clk),
        .rstn        (rstn),
        .x           (x64),
        .is_unsigned (uns64),
        .rm          (rm64),
        .in_valid    (iv64),
        .in_ready    (ir64),
        .y           (y64),
        .inexact     (inx64),
        .out_valid   (ov64),
        .out_ready   (or64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // 32-bit monitor: scoreboard pops, in_ready vs occupancy, stall stability.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rstn) begin
            occ       = 0;
            pend_in   = 1'b0;
            pend_out  = 1'b0;
            hold_pend = 1'b0;
        end else begin
            occ = occ + int'(pend_in) - int'(pend_out);
            check("in_ready_vs_occupancy", 64'(in_ready), 64'((occ < 3) || out_ready));
            if (hold_pend)
                check("stall_hold", {31'b0, out_valid, y, inexact}, {31'b0, 1'b1, hold_val});
            hold_pend = out_valid && !out_ready;
            hold_val  = {y, inexact};
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out32: got y=%h with empty scoreboard", y);
                end else begin
                    e = q32.pop_front();
                    check("result32", 64'({y, inexact}), 64'(e));
                end
            end
            pend_in  = in_valid && in_ready;
            pend_out = out_valid && out_ready;
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (rstn && ov64 && or64) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out64: got y=%h with empty scoreboard", y64);
            end else begin
                e = q64.pop_front();
                check("result64", 64'({y64, inx64}), 64'(e));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send32(input logic [31:0] xv, input logic u, input logic [1:0] r,
                          input logic [31:0] ey, input logic ei);
        int n = 0;
        x = xv; is_unsigned = u; rm = r; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send32_timeout: in_ready=0 after %0d cycles, required 1", n);
        end else begin
            q32.push_back({ey, ei});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send64(input logic [63:0] xv, input logic u,
                          input logic [31:0] ey, input logic ei);
        int n = 0;
        x64 = xv; uns64 = u; rm64 = 2'b00; iv64 = 1'b1;
        @(negedge clk);
        while (!ir64 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ir64) begin
            checks++;
            errors++;
            $display("FAIL send64_timeout: in_ready=0 after %0d cycles, required 1", n);
        end else begin
            q64.push_back({ey, ei});
        end
        @(posedge clk); #1;
        iv64 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        check(name, 64'(q32.size() + q64.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rstn = 1'b0; x = '0; is_unsigned = 1'b0; rm = 2'b00; in_valid = 1'b0; out_ready = 1'b1;
        x64 = '0; uns64 = 1'b0; rm64 = 2'b00; iv64 = 1'b0; or64 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_y", 64'(y), 64'd0);
        check("reset_inexact", 64'(inexact), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Latency from an empty pipeline.
        send32(32'h00000001, 1'b0, 2'b00, 32'h3F800000, 1'b0);
        n = 0;
        while (!out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("latency", 64'(n), 64'd3);
        @(posedge clk); #1;

        // Directed conversions.
        send32(32'hFFFFFFFF, 1'b0, 2'b00, 32'hBF800000, 1'b0);
        send32(32'h00000000, 1'b0, 2'b00, 32'h00000000, 1'b0);
        send32(32'h00000000, 1'b0, 2'b10, 32'h00000000, 1'b0);
        send32(32'h00000000, 1'b0, 2'b11, 32'h00000000, 1'b0);
        send32(32'h80000000, 1'b0, 2'b00, 32'hCF000000, 1'b0);
        send32(32'h80000000, 1'b1, 2'b00, 32'h4F000000, 1'b0);
        send32(32'h7FFFFFFF, 1'b0, 2'b00, 32'h4F000000, 1'b1);
        send32(32'h7FFFFFFF, 1'b0, 2'b01, E_MAX_RTZ,    1'b1);
        send32(32'h01000001, 1'b0, 2'b00, 32'h4B800000, 1'b1);
        send32(32'h01000001, 1'b0, 2'b11, E_TIE_RUP,    1'b1);
        send32(32'hFEFFFFFF, 1'b0, 2'b10, E_NEG_RDN,    1'b1);
        send32(32'hFEFFFFFF, 1'b0, 2'b11, 32'hCB800000, 1'b1);
        drain("drain_directed");

        // Back-pressure: fill with the consumer stalled, then random ready.
        out_ready = 1'b0;
        send32(32'h00000002, 1'b0, 2'b00, 32'h40000000, 1'b0);
        send32(32'h00000003, 1'b0, 2'b00, 32'h40400000, 1'b0);
        send32(32'hFFFFFFFE, 1'b0, 2'b00, 32'hC0000000, 1'b0);
        repeat (3) @(negedge clk);
        check("full_stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rand_ready = 1'b1;
        send32(32'h0000000A, 1'b0, 2'b00, 32'h41200000, 1'b0);
        send32(32'h00000064, 1'b0, 2'b00, 32'h42C80000, 1'b0);
        send32(32'h01000003, 1'b0, 2'b00, 32'h4B800002, 1'b1);
        send32(32'h00FFFFFF, 1'b0, 2'b00, 32'h4B7FFFFF, 1'b0);
        send32(32'h7FFFFFC0, 1'b0, 2'b00, 32'h4F000000, 1'b1);
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain("drain_backpressure");

        // 64-bit operands.
        send64(64'hFFFFFFFFFFFFFFFF, 1'b1, 32'h5F800000, 1'b1);
        send64(64'h0020000000000000, 1'b1, 32'h5A000000, 1'b0);
        send64(64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hBF800000, 1'b0);
        send64(64'h8000000000000000, 1'b0, 32'hDF000000, 1'b0);
        send64(64'h0000000000000000, 1'b1, 32'h00000000, 1'b0);
        drain("drain_64");

        // Reset with three operands in flight.
        out_ready = 1'b0;
        send32(32'h00000005, 1'b0, 2'b00, 32'h40A00000, 1'b0);
        send32(32'h00000006, 1'b0, 2'b00, 32'h40C00000, 1'b0);
        send32(32'h00000007, 1'b0, 2'b00, 32'h40E00000, 1'b0);
        rstn = 1'b0;
        q32.delete();
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send32(32'h00000002, 1'b0, 2'b00, 32'h40000000, 1'b0);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
